// File: rtl/fetch_decode_execute.sv
// Single-cycle LEGv8-subset core: PC, 32x64 register file, NZVC flags, decode, execute.
// Define CPU_MUL_EN to add the MUL instruction; otherwise that encoding is a NOP.
module fetch_decode_execute #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic        dmem_we,
  output logic        dmem_re,
  output logic [3:0]  dmem_xfer_size,
  input  logic [63:0] dmem_rdata,
  output logic [63:0] pc,
  output logic [3:0]  flags
);

  logic [4:0]  rd, rn, rm;
  logic [5:0]  shamt;
  logic [11:0] imm12;
  logic [8:0]  imm9;
  logic [18:0] imm19;
  logic [25:0] imm26;
  logic [10:0] op;

  assign rd    = imem_instr[4:0];
  assign rn    = imem_instr[9:5];
  assign rm    = imem_instr[20:16];
  assign shamt = imem_instr[15:10];
  assign imm12 = imem_instr[21:10];
  assign imm9  = imem_instr[20:12];
  assign imm19 = imem_instr[23:5];
  assign imm26 = imem_instr[25:0];
  assign op    = imem_instr[31:21];

  logic is_addi, is_adds, is_subs, is_and, is_eor;
  logic is_lsl, is_lsr, is_ldur, is_ldurb, is_stur, is_sturb;
  logic is_b, is_bl, is_br, is_cbz, is_blt;

  assign is_addi  = imem_instr[31:22] == 10'b1001000100;
  assign is_adds  = op == 11'b10101011000;
  assign is_subs  = op == 11'b11101011000;
  assign is_and   = op == 11'b10001010000;
  assign is_eor   = op == 11'b11001010000;
  assign is_lsl   = op == 11'b11010011011;
  assign is_lsr   = op == 11'b11010011010;
  assign is_ldur  = op == 11'b11111000010;
  assign is_ldurb = op == 11'b00111000010;
  assign is_stur  = op == 11'b11111000000;
  assign is_sturb = op == 11'b00111000000;
  assign is_b     = imem_instr[31:26] == 6'b000101;
  assign is_bl    = imem_instr[31:26] == 6'b100101;
  assign is_br    = op == 11'b11010110000;
  assign is_cbz   = imem_instr[31:24] == 8'b10110100;
  assign is_blt   = imem_instr[31:24] == 8'b01010100
                 && imem_instr[4:0] == 5'b01011;

`ifdef CPU_MUL_EN
  logic is_mul;
  assign is_mul = op == 11'b10011011000 && shamt == 6'b011111;
`endif

  // Entry 31 is never written, so it stays at its reset value of zero.
  logic [63:0] x [32];
  logic [63:0] ra, rb;
  logic [4:0]  rb_idx;

  assign rb_idx = (is_stur | is_sturb | is_cbz) ? rd : rm;
  assign ra     = (rn == 5'd31) ? '0 : x[rn];
  assign rb     = (rb_idx == 5'd31) ? '0 : x[rb_idx];

  logic [63:0] opb;
  logic [64:0] sum;
  logic        ovf;
  logic [3:0]  flags_new;

  assign opb = is_subs ? ~rb : rb;
  assign sum = {1'b0, ra} + {1'b0, opb} + 65'(is_subs);
  assign ovf = (ra[63] == opb[63]) && (sum[63] != ra[63]);
  assign flags_new = {sum[63], sum[63:0] == '0, ovf, sum[64]};

  logic [63:0] off9, off19, off26, pc4;

  assign off9  = {{55{imm9[8]}}, imm9};
  assign off19 = {{43{imm19[18]}}, imm19, 2'b00};
  assign off26 = {{36{imm26[25]}}, imm26, 2'b00};
  assign pc4   = pc + 64'd4;

  assign imem_addr      = pc;
  assign dmem_addr      = ra + off9;
  assign dmem_wdata     = rb;
  assign dmem_we        = (is_stur | is_sturb) & ~reset;
  assign dmem_re        = (is_ldur | is_ldurb) & ~reset;
  assign dmem_xfer_size = (is_ldur | is_stur)   ? 4'd8 :
                          (is_ldurb | is_sturb) ? 4'd1 : 4'd0;

  logic        wb_en, fl_en;
  logic [4:0]  wb_idx;
  logic [63:0] wb_data, next_pc;

  always_comb begin
    wb_en   = 1'b0;
    fl_en   = 1'b0;
    wb_idx  = rd;
    wb_data = '0;
    next_pc = pc4;
    unique case (1'b1)
      is_addi: begin
        wb_en   = 1'b1;
        wb_data = ra + {52'd0, imm12};
      end
      is_adds, is_subs: begin
        wb_en   = 1'b1;
        fl_en   = 1'b1;
        wb_data = sum[63:0];
      end
      is_and: begin
        wb_en   = 1'b1;
        wb_data = ra & rb;
      end
      is_eor: begin
        wb_en   = 1'b1;
        wb_data = ra ^ rb;
      end
      is_lsl: begin
        wb_en   = 1'b1;
        wb_data = ra << shamt;
      end
      is_lsr: begin
        wb_en   = 1'b1;
        wb_data = ra >> shamt;
      end
      is_ldur: begin
        wb_en   = 1'b1;
        wb_data = dmem_rdata;
      end
      is_ldurb: begin
        wb_en   = 1'b1;
        wb_data = {56'd0, dmem_rdata[7:0]};
      end
`ifdef CPU_MUL_EN
      is_mul: begin
        wb_en   = 1'b1;
        wb_data = ra * rb;
      end
`endif
      is_b:   next_pc = pc + off26;
      is_bl: begin
        wb_en   = 1'b1;
        wb_idx  = 5'd30;
        wb_data = pc4;
        next_pc = pc + off26;
      end
      is_br:  next_pc = ra;
      is_cbz: if (rb == '0) next_pc = pc + off19;
      // LT reads the flags as they stood before this instruction.
      is_blt: if (flags[3] != flags[1]) next_pc = pc + off19;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      flags <= '0;
      for (int i = 0; i < 32; i++) x[i] <= '0;
    end else begin
      pc <= next_pc;
      if (fl_en) flags <= flags_new;
      if (wb_en && wb_idx != 5'd31) x[wb_idx] <= wb_data;
    end
  end

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Bench for fetch_decode_execute: directed program plus random
// instruction stream checked against an architectural model.
module tb_fetch_decode_execute;

  localparam logic [63:0] RST_PC = 64'd0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr = '0;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_we;
  logic        dmem_re;
  logic [3:0]  dmem_xfer_size;
  logic [63:0] dmem_rdata = '0;
  logic [63:0] pc;
  logic [3:0]  flags;

  fetch_decode_execute #(.RESET_PC(RST_PC)) dut (
    .clk(clk),
    .reset(reset),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we),
    .dmem_re(dmem_re),
    .dmem_xfer_size(dmem_xfer_size),
    .dmem_rdata(dmem_rdata),
    .pc(pc),
    .flags(flags)
  );

  always #5 clk = ~clk;

  typedef enum int {
    K_ADDI, K_ADDS, K_SUBS, K_AND, K_EOR, K_LSL, K_LSR,
    K_LDUR, K_LDURB, K_STUR, K_STURB, K_B, K_BL, K_BR,
    K_CBZ, K_BLT, K_NBC, K_NZ, K_MUL
  } kind_t;

  int n_checks = 0;
  int n_errs = 0;

  logic [63:0] mx [32];
  logic [63:0] mpc;
  logic [3:0]  mf;

  logic [63:0] last_wdata, last_addr;
  logic [3:0]  last_xfer;
  logic        last_we;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input kind_t k, input logic [4:0] d,
                                      input logic [4:0] n, input logic [4:0] m,
                                      input logic [25:0] imm);
    logic [4:0] cnd;
    cnd = (imm[4:0] == 5'b01011) ? 5'b00000 : imm[4:0];
    case (k)
      K_ADDI:  return {10'b1001000100, imm[11:0], n, d};
      K_ADDS:  return {11'b10101011000, m, imm[5:0], n, d};
      K_SUBS:  return {11'b11101011000, m, imm[5:0], n, d};
      K_AND:   return {11'b10001010000, m, imm[5:0], n, d};
      K_EOR:   return {11'b11001010000, m, imm[5:0], n, d};
      K_LSL:   return {11'b11010011011, m, imm[5:0], n, d};
      K_LSR:   return {11'b11010011010, m, imm[5:0], n, d};
      K_LDUR:  return {11'b11111000010, imm[8:0], 2'b00, n, d};
      K_LDURB: return {11'b00111000010, imm[8:0], 2'b00, n, d};
      K_STUR:  return {11'b11111000000, imm[8:0], 2'b00, n, d};
      K_STURB: return {11'b00111000000, imm[8:0], 2'b00, n, d};
      K_B:     return {6'b000101, imm};
      K_BL:    return {6'b100101, imm};
      K_BR:    return {11'b11010110000, 5'b11111, 6'd0, n, 5'd0};
      K_CBZ:   return {8'b10110100, imm[18:0], d};
      K_BLT:   return {8'b01010100, imm[18:0], 5'b01011};
      K_NBC:   return {8'b01010100, imm[18:0], cnd};
      K_MUL:   return {11'b10011011000, m, 6'b011111, n, d};
      default: return 32'd0;
    endcase
  endfunction

  // Apply one instruction, compare outputs with the model, advance one edge.
  task automatic run(input kind_t k, input logic [4:0] d, input logic [4:0] n,
                     input logic [4:0] m, input logic [25:0] imm,
                     input logic [63:0] rdata);
    logic [63:0] a, b, t, r, npc, off9;
    logic signed [64:0] s;
    logic [3:0] nf;
    logic [4:0] wa;
    bit wr, st, ld;
    imem_instr = enc(k, d, n, m, imm);
    dmem_rdata = rdata;
    #1;
    a = mx[n];
    b = mx[m];
    t = mx[d];
    off9 = {{55{imm[8]}}, imm[8:0]};
    st = (k == K_STUR) || (k == K_STURB);
    ld = (k == K_LDUR) || (k == K_LDURB);
    last_wdata = dmem_wdata;
    last_addr = dmem_addr;
    last_xfer = dmem_xfer_size;
    last_we = dmem_we;
    chk("pc", pc, mpc);
    chk("imem_addr", imem_addr, mpc);
    chk("flags", flags, mf);
    chk("dmem_we", dmem_we, st);
    chk("dmem_re", dmem_re, ld);
    chk("xfer_size", dmem_xfer_size,
        (k == K_STUR || k == K_LDUR) ? 8 : (st || ld) ? 1 : 0);
    if (st || ld) chk("dmem_addr", dmem_addr, a + off9);
    if (st) chk("dmem_wdata", dmem_wdata, t);

    npc = mpc + 4;
    nf = mf;
    wr = 0;
    wa = d;
    r = '0;
    case (k)
      K_ADDI: begin wr = 1; r = a + 64'(imm[11:0]); end
      K_ADDS: begin
        wr = 1;
        r = a + b;
        s = $signed({a[63], a}) + $signed({b[63], b});
        nf = {r[63], r == 0, s[64] != s[63], r < a};
      end
      K_SUBS: begin
        wr = 1;
        r = a - b;
        s = $signed({a[63], a}) - $signed({b[63], b});
        nf = {r[63], r == 0, s[64] != s[63], a >= b};
      end
      K_AND:   begin wr = 1; r = a & b; end
      K_EOR:   begin wr = 1; r = a ^ b; end
      K_LSL:   begin wr = 1; r = a << imm[5:0]; end
      K_LSR:   begin wr = 1; r = a >> imm[5:0]; end
      K_LDUR:  begin wr = 1; r = rdata; end
      K_LDURB: begin wr = 1; r = 64'(rdata[7:0]); end
      K_B:     npc = mpc + {{36{imm[25]}}, imm, 2'b00};
      K_BL: begin
        wr = 1; wa = 5'd30; r = mpc + 4;
        npc = mpc + {{36{imm[25]}}, imm, 2'b00};
      end
      K_BR:  npc = a;
      K_CBZ: if (t == 0) npc = mpc + {{43{imm[18]}}, imm[18:0], 2'b00};
      K_BLT: if (mf[3] != mf[1]) npc = mpc + {{43{imm[18]}}, imm[18:0], 2'b00};
`ifdef CPU_MUL_EN
      K_MUL: begin wr = 1; r = a * b; end
`endif
      default: ;
    endcase
    if (wr && wa != 5'd31) mx[wa] = r;
    mf = nf;
    mpc = npc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    imem_instr = enc(K_STUR, 5'd0, 5'd31, 5'd0, 26'd0);
    repeat (cyc) begin
      #1;
      chk("we_in_reset", dmem_we, 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    mpc = RST_PC;
    mf = '0;
    for (int i = 0; i < 32; i++) mx[i] = '0;
  endtask

  function automatic logic [4:0] rreg();
    int p;
    p = $urandom_range(0, 11);
    if (p == 0) return 5'd31;
    if (p == 1) return 5'd30;
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    do_reset(2);
    chk("rst_pc", pc, 64'd0);
    chk("rst_flags", flags, 4'd0);

    run(K_ADDI, 0, 31, 0, 5, 0);
    run(K_ADDI, 1, 0, 0, 3, 0);
    chk("pc_after_two", pc, 64'd8);
    run(K_STUR, 0, 31, 0, 0, 0);
    chk("x0_is_5", last_wdata, 64'd5);
    run(K_STUR, 1, 31, 0, 0, 0);
    chk("x1_is_8", last_wdata, 64'd8);
    run(K_SUBS, 2, 0, 1, 0, 0);
    chk("subs_flags", flags, 4'b1000);
    run(K_STUR, 2, 31, 0, 0, 0);
    chk("x2_neg3", last_wdata, 64'hFFFF_FFFF_FFFF_FFFD);
    run(K_BLT, 0, 0, 0, 4, 0);
    chk("blt_pc", pc, 64'd40);

    run(K_STUR, 1, 31, 0, 16, 0);
    chk("stur_we", last_we, 1);
    chk("stur_addr", last_addr, 64'd16);
    chk("stur_wdata", last_wdata, 64'd8);
    chk("stur_size", last_xfer, 4'd8);
    run(K_LDURB, 3, 31, 0, 16, 64'h1234);
    chk("ldurb_size", last_xfer, 4'd1);
    run(K_STUR, 3, 31, 0, 0, 0);
    chk("x3_byte", last_wdata, 64'h34);

    run(K_ADDI, 5, 31, 0, 26'h20, 0);
    run(K_BR, 0, 5, 0, 0, 0);
    chk("br_pc", pc, 64'h20);
    run(K_BL, 0, 0, 0, 26'h3FF_FFFE, 0);
    chk("bl_pc", pc, 64'h18);
    run(K_STUR, 30, 31, 0, 0, 0);
    chk("x30_link", last_wdata, 64'h24);
    run(K_BR, 0, 30, 0, 0, 0);
    chk("br_x30", pc, 64'h24);

    run(K_ADDI, 5, 31, 0, 26'h40, 0);
    run(K_BR, 0, 5, 0, 0, 0);
    run(K_CBZ, 31, 0, 0, 3, 0);
    chk("cbz_taken", pc, 64'h4C);
    run(K_BR, 0, 5, 0, 0, 0);
    run(K_CBZ, 1, 0, 0, 3, 0);
    chk("cbz_not", pc, 64'h44);
    run(K_ADDI, 31, 0, 0, 1, 0);
    run(K_STUR, 31, 31, 0, 0, 0);
    chk("x31_zero", last_wdata, 64'd0);

    do_reset(1);
    chk("mid_rst_pc", pc, RST_PC);
    chk("mid_rst_flags", flags, 4'd0);
    run(K_STUR, 0, 31, 0, 0, 0);
    chk("mid_rst_x0", last_wdata, 64'd0);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset(1);
      else run(kind_t'($urandom_range(0, 18)), rreg(), rreg(), rreg(),
               26'($urandom), {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode_execute.md
Name: fetch_decode_execute

Overview:
- Fetch, decode, register-file and execute core of the single-cycle 64-bit LEGv8-subset CPU.
- Holds the PC, the 32x64 register file and the NZVC flag register.
- Decodes each instruction, drives the external instruction and data memories, performs write-back, and resolves the next PC, all in one cycle.
- The data-memory and top-level wrapper sit outside this block.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.

Ports:
- clk in 1: single clock. All state updates on its rising edge.
- reset in 1: synchronous, active-high.
- imem_addr out 64: current PC. Equals pc.
- imem_instr in 32: instruction at imem_addr. Combinational, same cycle.
- dmem_addr out 64: ALU result (X[Rn] + sign-extended imm9).
- dmem_wdata out 64: X[Rt].
- dmem_we out 1: store strobe.
- dmem_re out 1: load strobe.
- dmem_xfer_size out 4: 8 for LDUR/STUR, 1 for LDURB/STURB, 0 otherwise.
- dmem_rdata in 64: load data. Combinational, same cycle.
- pc out 64: current PC.
- flags out 4: {N,Z,V,C} register.

Behaviour:
- Reset:
  - PC=RESET_PC, X0..X30=0, flags=0.
  - dmem_we=0 while reset is high.
  - Reset applied mid-program overrides all writes on that edge.
- Decode fields: Rd=[4:0], Rn=[9:5], Rm=[20:16], Rt=[4:0], shamt=[15:10], imm12=[21:10], imm9=[20:12], imm19=[23:5], imm26=[25:0].
- Opcodes, compared on the bits shown:
  - ADDI [31:22]=1001000100: Rd = Rn + zero-extended imm12. Flags unchanged.
  - ADDS [31:21]=10101011000: Rd = Rn + Rm. Sets NZVC.
  - SUBS 11101011000: Rd = Rn - Rm. Sets NZVC.
  - C is the carry-out of Rn + ~Rm + 1.
  - AND 10001010000 and EOR 11001010000: bitwise. Flags unchanged.
  - LSL 11010011011 and LSR 11010011010: Rd = Rn shifted by shamt. Logical shift, zeros shifted in.
  - LDUR 11111000010: Rt = dmem_rdata.
  - LDURB 00111000010: Rt = zero-extended dmem_rdata[7:0].
  - STUR 11111000000 and STURB 00111000000: dmem_we=1. No register write.
  - B [31:26]=000101: PC += SignExt(imm26)<<2.
  - BL 100101: X30 = PC+4, and PC += SignExt(imm26)<<2.
  - BR [31:21]=11010110000: PC = X[Rn].
  - CBZ [31:24]=10110100: if X[Rt]==0, PC += SignExt(imm19)<<2.
  - B.cond [31:24]=01010100 with [4:0]=01011 (LT): taken when N!=V, using the flags register value before this cycle's update.
- Any other opcode, including B.cond with another cond field, is a NOP:
  - No register, flag or memory write.
  - PC += 4.
- Register file:
  - Two combinational read ports. Second port reads Rt for STUR/STURB/CBZ, Rm otherwise.
  - X31 always reads 0. Writes to X31 are discarded.
  - Write occurs at the rising edge. A read of the register being written in the same cycle returns the old value.
- Flags update only on ADDS/SUBS, at the same edge as the register write.
  - N = result[63], Z = (result==0).
  - V = signed overflow; C = unsigned carry.
- Arithmetic is 64-bit and wraps modulo 2^64. PC arithmetic also wraps.
- Branch targets use the PC of the branching instruction. Not-taken paths use PC+4.
- Next PC is latched at the rising edge, so each instruction has one-cycle latency.

Optional Feature:
- CPU_MUL_EN defined: adds MUL, [31:21]=10011011000 with shamt=011111. Rd = low 64 bits of Rn*Rm. Flags unchanged.
- CPU_MUL_EN undefined: that encoding is a NOP. No multiplier is synthesized.

Test Plan:
- Reset held 2 cycles, then released, with imem returning ADDI X0,X31,#5 then ADDI X1,X0,#3 -> pc=0, 4, 8 on successive cycles; X0=5 and X1=8.
- X0=5, X1=8, SUBS X2,X0,X1 -> X2=0xFFFF_FFFF_FFFF_FFFD, flags N=1 Z=0 V=0 C=0. Next B.LT with imm19=4 -> PC += 16.
- STUR X1,[X31,#16] -> dmem_we=1, dmem_addr=16, dmem_wdata=8, xfer_size=8. LDURB X3,[X31,#16] with dmem_rdata=0x1234 -> X3=0x34, xfer_size=1.
- BL imm26=-2 at pc=0x20 -> X30=0x24, pc=0x18. Then BR X30 -> pc=0x24.
- CBZ X31 imm19=3 at pc=0x40 -> pc=0x4C. CBZ on X1=8 -> pc=0x44. ADDI X31,X0,#1 -> X31 still reads 0.
- Assert reset mid-program, after X0 has been set -> next edge gives pc=RESET_PC, X0=0, flags=0.
